s2mm_burst_writer: RTL

//  Memory-write stage directly downstream of the triple-buffer sync manager.
//  - Consumes its 72-bit S2MM command stream (ADDR + BTT).
//  - Moves BTT bytes of the 32-bit sample stream into DDR as AXI4 INCR bursts of up to 16 beats.
//  - Reports one status byte per command.
//  - Acts as a lightweight replacement for the DataMover S2MM path.

---
 rtl/s2mm_burst_writer_if.sv | 45 ++++
 rtl/s2mm_burst_writer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/s2mm_burst_writer_if.sv
// Bus bundle for the S2MM burst writer: command, sample and status streams plus
// the AXI4 write channels. "master" is the writer side, "slave" the environment.
interface s2mm_burst_writer_if #(
    parameter int MM_ADDR_WIDTH = 32
);
    logic                       S_AXIS_CMD_tvalid;
    logic                       S_AXIS_CMD_tready;
    logic [MM_ADDR_WIDTH+39:0]  S_AXIS_CMD_tdata;
    logic                       S_AXIS_tvalid;
    logic                       S_AXIS_tready;
    logic [31:0]                S_AXIS_tdata;
    logic [MM_ADDR_WIDTH-1:0]   M_AXI_awaddr;
    logic [7:0]                 M_AXI_awlen;
    logic [2:0]                 M_AXI_awsize;
    logic [1:0]                 M_AXI_awburst;
    logic                       M_AXI_awvalid;
    logic                       M_AXI_awready;
    logic [31:0]                M_AXI_wdata;
    logic [3:0]                 M_AXI_wstrb;
    logic                       M_AXI_wlast;
    logic                       M_AXI_wvalid;
    logic                       M_AXI_wready;
    logic [1:0]                 M_AXI_bresp;
    logic                       M_AXI_bvalid;
    logic                       M_AXI_bready;
    logic                       M_AXIS_STS_tvalid;
    logic                       M_AXIS_STS_tready;
    logic [7:0]                 M_AXIS_STS_tdata;

    modport master (
        input  S_AXIS_CMD_tvalid, S_AXIS_CMD_tdata, S_AXIS_tvalid, S_AXIS_tdata,
               M_AXI_awready, M_AXI_wready, M_AXI_bresp, M_AXI_bvalid, M_AXIS_STS_tready,
        output S_AXIS_CMD_tready, S_AXIS_tready, M_AXI_awaddr, M_AXI_awlen, M_AXI_awsize,
               M_AXI_awburst, M_AXI_awvalid, M_AXI_wdata, M_AXI_wstrb, M_AXI_wlast,
               M_AXI_wvalid, M_AXI_bready, M_AXIS_STS_tvalid, M_AXIS_STS_tdata
    );

    modport slave (
        output S_AXIS_CMD_tvalid, S_AXIS_CMD_tdata, S_AXIS_tvalid, S_AXIS_tdata,
               M_AXI_awready, M_AXI_wready, M_AXI_bresp, M_AXI_bvalid, M_AXIS_STS_tready,
        input  S_AXIS_CMD_tready, S_AXIS_tready, M_AXI_awaddr, M_AXI_awlen, M_AXI_awsize,
               M_AXI_awburst, M_AXI_awvalid, M_AXI_wdata, M_AXI_wstrb, M_AXI_wlast,
               M_AXI_wvalid, M_AXI_bready, M_AXIS_STS_tvalid, M_AXIS_STS_tdata
    );
endinterface

// File: rtl/s2mm_burst_writer.sv
// S2MM burst writer: turns one ADDR/BTT command into AXI4 INCR bursts of up to
// 16 beats fed straight from the sample stream, then emits one status byte.
//   state     | meaning
//   ST_IDLE   | waiting for a command
//   ST_ADDR   | presenting the burst address
//   ST_DATA   | passing samples through to the write channel
//   ST_RESP   | waiting for the burst write response
//   ST_STATUS | presenting the status byte
module s2mm_burst_writer #(
    parameter int MM_ADDR_WIDTH = 32
) (
    input  logic                  SYS_aclk,
    input  logic                  SYS_areset,
    s2mm_burst_writer_if.master   bus
);
    localparam int AW = MM_ADDR_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_STATUS
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_cmd_rdy;
    logic [AW-1:0]  r_awaddr;
    logic [7:0]     r_awlen;
    logic [7:0]     r_beat_cnt;
    logic [20:0]    r_beats_left;
    logic [3:0]     r_tag;
    logic           r_slverr;
    logic           r_decerr;
    logic [7:0]     r_sts_tdata;

    logic [AW-1:0]  w_cmd_addr;
    logic [22:0]    w_cmd_btt;
    logic [3:0]     w_cmd_tag;
    logic           w_cmd_bad;
    logic           w_cmd_fire;
    logic           w_beat;
    logic           w_last_beat;
    logic           w_b_fire;
    logic [20:0]    w_burst_beats;
    logic [20:0]    w_beats_rem;
    logic [AW-1:0]  w_burst_bytes;
    logic           w_slverr_nxt;
    logic           w_decerr_nxt;
    logic           w_unused;

    function automatic logic [7:0] burst_len(input logic [20:0] beats);
        if (beats >= 21'd16)
            return 8'd15;
        return {3'b000, beats[4:0]} - 8'd1;
    endfunction

    assign w_cmd_btt  = bus.S_AXIS_CMD_tdata[22:0];
    assign w_cmd_addr = bus.S_AXIS_CMD_tdata[AW+31:32];
    assign w_cmd_tag  = bus.S_AXIS_CMD_tdata[AW+35:AW+32];
    // TYPE/DSA/EOF/DRR/RSVD carry no meaning for this writer
    assign w_unused   = ^{bus.S_AXIS_CMD_tdata[AW+39:AW+36], bus.S_AXIS_CMD_tdata[31:23]};

    assign w_cmd_bad   = (w_cmd_btt == 23'd0) || (w_cmd_btt[1:0] != 2'b00) || (w_cmd_addr[5:0] != 6'd0);
    assign w_cmd_fire  = r_cmd_rdy && bus.S_AXIS_CMD_tvalid;
    assign w_beat      = (r_state == ST_DATA) && bus.S_AXIS_tvalid && bus.M_AXI_wready;
    assign w_last_beat = w_beat && (r_beat_cnt == r_awlen);
    assign w_b_fire    = (r_state == ST_RESP) && bus.M_AXI_bvalid;

    assign w_burst_beats = {13'd0, r_awlen} + 21'd1;
    assign w_beats_rem   = r_beats_left - w_burst_beats;
    assign w_burst_bytes = AW'({w_burst_beats, 2'b00});
    assign w_slverr_nxt  = r_slverr || (bus.M_AXI_bresp == 2'b10);
    assign w_decerr_nxt  = r_decerr || (bus.M_AXI_bresp == 2'b11);

    assign bus.M_AXI_awsize     = 3'b010;
    assign bus.M_AXI_awburst    = 2'b01;
    assign bus.M_AXI_wstrb      = 4'hF;
    assign bus.M_AXI_wdata      = bus.S_AXIS_tdata;
    assign bus.M_AXI_awaddr     = r_awaddr;
    assign bus.M_AXI_awlen      = r_awlen;
    assign bus.M_AXIS_STS_tdata = r_sts_tdata;
    assign bus.S_AXIS_CMD_tready = r_cmd_rdy;

    always_ff @(posedge SYS_aclk or posedge SYS_areset) begin
        if (SYS_areset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt           = r_state;
        bus.M_AXI_awvalid     = 1'b0;
        bus.M_AXI_wvalid      = 1'b0;
        bus.M_AXI_wlast       = 1'b0;
        bus.S_AXIS_tready     = 1'b0;
        bus.M_AXI_bready      = 1'b0;
        bus.M_AXIS_STS_tvalid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_fire)
                    w_state_nxt = w_cmd_bad ? ST_STATUS : ST_ADDR;
            end
            ST_ADDR: begin
                bus.M_AXI_awvalid = 1'b1;
                if (bus.M_AXI_awready)
                    w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                bus.M_AXI_wvalid  = bus.S_AXIS_tvalid;
                bus.S_AXIS_tready = bus.M_AXI_wready;
                bus.M_AXI_wlast   = (r_beat_cnt == r_awlen);
                if (w_last_beat)
                    w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                bus.M_AXI_bready = 1'b1;
                if (bus.M_AXI_bvalid)
                    w_state_nxt = (w_beats_rem != 21'd0) ? ST_ADDR : ST_STATUS;
            end
            ST_STATUS: begin
                bus.M_AXIS_STS_tvalid = 1'b1;
                if (bus.M_AXIS_STS_tready)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Command ready is registered so it stays low for the first cycle after reset
    always_ff @(posedge SYS_aclk or posedge SYS_areset) begin
        if (SYS_areset) begin
            r_cmd_rdy    <= 1'b0;
            r_awaddr     <= '0;
            r_awlen      <= '0;
            r_beat_cnt   <= '0;
            r_beats_left <= '0;
            r_tag        <= '0;
            r_slverr     <= 1'b0;
            r_decerr     <= 1'b0;
            r_sts_tdata  <= '0;
        end else begin
            r_cmd_rdy <= (w_state_nxt == ST_IDLE);
            if (w_cmd_fire) begin
                r_awaddr     <= w_cmd_addr;
                r_beats_left <= w_cmd_btt[22:2];
                r_awlen      <= w_cmd_bad ? 8'd0 : burst_len(w_cmd_btt[22:2]);
                r_tag        <= w_cmd_tag;
                r_slverr     <= 1'b0;
                r_decerr     <= 1'b0;
                r_beat_cnt   <= '0;
                if (w_cmd_bad)
                    r_sts_tdata <= {4'b0001, w_cmd_tag};
            end
            if (w_beat)
                r_beat_cnt <= w_last_beat ? 8'd0 : r_beat_cnt + 8'd1;
            if (w_b_fire) begin
                r_slverr     <= w_slverr_nxt;
                r_decerr     <= w_decerr_nxt;
                r_beats_left <= w_beats_rem;
                r_awaddr     <= r_awaddr + w_burst_bytes;
                r_awlen      <= burst_len(w_beats_rem);
                if (w_beats_rem == 21'd0)
                    r_sts_tdata <= {~(w_slverr_nxt | w_decerr_nxt), w_slverr_nxt, w_decerr_nxt, 1'b0, r_tag};
            end
        end
    end
endmodule
